// File: rtl/clint_timer_if.sv
// Core data-bus connection for the CLINT timer block.
// The core drives the request side; the slave returns a one-cycle ready pulse with read data.
interface clint_timer_if;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_write;
    logic        bus_valid;
    logic [31:0] bus_rdata;
    logic        bus_ready;

    modport master (
        output bus_addr,
        output bus_wdata,
        output bus_write,
        output bus_valid,
        input  bus_rdata,
        input  bus_ready
    );

    modport slave (
        input  bus_addr,
        input  bus_wdata,
        input  bus_write,
        input  bus_valid,
        output bus_rdata,
        output bus_ready
    );
endinterface

// File: rtl/clint_timer.sv
// CLINT-style machine timer and software interrupt unit on the core data bus.
// Holds mtime/mtimecmp/msip and drives the registered mtip and msip interrupt lines.
module clint_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    clint_timer_if.slave bus,
    output logic         mtip,
    output logic         msip
);
    localparam int unsigned    PresW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PresW-1:0] PresMax = PresW'(TICK_DIV - 1);

    localparam logic [13:0] WordMsip     = 14'h0000;
    localparam logic [13:0] WordMtcmpLo  = 14'h1000;
    localparam logic [13:0] WordMtcmpHi  = 14'h1001;
    localparam logic [13:0] WordMtimeLo  = 14'h2FFE;
    localparam logic [13:0] WordMtimeHi  = 14'h2FFF;

    typedef enum logic {StIdle, StResp} state_e;

    state_e           state_q, state_d;
    logic [63:0]      mtime_q, mtime_d;
    logic [63:0]      mtimecmp_q, mtimecmp_d;
    logic [PresW-1:0] pres_q, pres_d;
    logic             msip_q, msip_d;
    logic             mtip_q, mtip_d;
    logic             ready_q, ready_d;
    logic [31:0]      rdata_q, rdata_d;

    logic        sel, req, tick;
    logic [13:0] word;
    logic        unused_addr;

    assign unused_addr = ^bus.bus_addr[1:0];
    assign word        = bus.bus_addr[15:2];
    assign sel         = bus.bus_addr[31:16] == BASE_ADDR[31:16];
    assign req         = (state_q == StIdle) && bus.bus_valid && sel;
    assign tick        = pres_q == PresMax;

    always_comb begin
        pres_d     = tick ? '0 : pres_q + PresW'(1);
        mtime_d    = mtime_q + {63'b0, tick};
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        rdata_d    = '0;

        // A write to either mtime half replaces this cycle's increment entirely.
        if (req && bus.bus_write) begin
            case (word)
                WordMsip:    msip_d           = bus.bus_wdata[0];
                WordMtcmpLo: mtimecmp_d[31:0]  = bus.bus_wdata;
                WordMtcmpHi: mtimecmp_d[63:32] = bus.bus_wdata;
                WordMtimeLo: mtime_d          = {mtime_q[63:32], bus.bus_wdata};
                WordMtimeHi: mtime_d          = {bus.bus_wdata, mtime_q[31:0]};
                default:     ;
            endcase
        end

        if (req && !bus.bus_write) begin
            case (word)
                WordMsip:    rdata_d = {31'b0, msip_q};
                WordMtcmpLo: rdata_d = mtimecmp_q[31:0];
                WordMtcmpHi: rdata_d = mtimecmp_q[63:32];
                WordMtimeLo: rdata_d = mtime_q[31:0];
                WordMtimeHi: rdata_d = mtime_q[63:32];
                default:     rdata_d = '0;
            endcase
        end

        // RESP always falls back to IDLE; req can only be set in IDLE.
        state_d = req ? StResp : StIdle;
        ready_d = req;
        mtip_d  = mtime_d >= mtimecmp_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            pres_q     <= '0;
            msip_q     <= 1'b0;
            mtip_q     <= 1'b0;
            ready_q    <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            pres_q     <= pres_d;
            msip_q     <= msip_d;
            mtip_q     <= mtip_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
        end
    end

    assign bus.bus_ready = ready_q;
    assign bus.bus_rdata = rdata_q;
    assign mtip          = mtip_q;
    assign msip          = msip_q;
endmodule

// File: doc/clint_timer.md
Name: clint_timer

Overview:
- Memory-mapped machine timer and software-interrupt unit (CLINT-style) on the nexusV_core data bus.
- Sits downstream of the core as a bus slave: decodes core accesses, holds mtime/mtimecmp/msip, and drives the core's mtip and msip inputs.
- Replaces the tied-off interrupt lines used in the current CSR/trap bring-up.

Parameters:
- BASE_ADDR, 32'h0200_0000, base address; the block responds when bus_addr[31:16] == BASE_ADDR[31:16].
- TICK_DIV, 1, clock cycles per mtime increment (>=1); 1 = increment every cycle.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- bus_addr  input  32  byte address from core
- bus_wdata  input  32  write data
- bus_write  input  1  1 = write, 0 = read
- bus_valid  input  1  request valid; core holds it until bus_ready is seen
- bus_rdata  output  32  read data, valid only while bus_ready=1
- bus_ready  output  1  one-cycle completion pulse
- mtip  output  1  machine timer interrupt pending
- msip  output  1  machine software interrupt pending

Behaviour:
- Reset: single clock; reset is synchronous and active-low (clk, rst_n). At a clk edge with rst_n=0:
  - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip reg=0, prescaler=0, FSM=IDLE.
  - Outputs: bus_ready=0, bus_rdata=0, mtip=0, msip=0.
  - Reset mid-transaction drops the response: no bus_ready and no register write.
- Register map (offset = bus_addr[15:0], word aligned, bus_addr[1:0] ignored):
  - 0x0000 msip: bit0 read/write; upper bits read 0.
  - 0x4000 mtimecmp[31:0]; 0x4004 mtimecmp[63:32].
  - 0xBFF8 mtime[31:0]; 0xBFFC mtime[63:32].
  - Any other offset reads 0; writes there are ignored but still get bus_ready.
- Bus FSM: two states, IDLE and RESP.
  - IDLE -> RESP when bus_valid=1 and the address is selected.
  - Write data is committed on that same edge; read data is captured into bus_rdata on that edge.
  - In RESP: bus_ready=1 for exactly one cycle, then the FSM returns unconditionally to IDLE.
  - Fixed latency: bus_ready asserts in the cycle after valid is first sampled in IDLE.
  - Unselected address: the FSM stays in IDLE and bus_ready stays 0 (another slave responds).
  - The core must deassert bus_valid in the cycle after bus_ready. If valid is still high in IDLE, it is a new request.
  - bus_rdata=0 whenever bus_ready=0.
- Timebase:
  - Prescaler counts 0..TICK_DIV-1. mtime += 1 on the cycle the prescaler wraps.
  - mtime is 64-bit and wraps from all-ones to 0.
  - A bus write to an mtime half takes priority over that cycle's increment. The written half takes wdata, the other half holds, and there is no carry in that cycle.
- Interrupts (registered, 1-cycle latency from the state change):
  - mtip <= (mtime_next >= mtimecmp_next), unsigned 64-bit compare using post-write, post-increment values.
  - msip output = msip register bit0.
  - mtip is level, not sticky: it clears once software writes mtimecmp above mtime.
- Simultaneous events: a 32-bit half write of mtimecmp is compared immediately. Software writes hi=all-ones first to avoid spurious mtip; the block does not protect against this.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with bus_valid=1 -> bus_ready=0, mtip=0, msip=0; after release, read 0x4004 -> 0xFFFFFFFF.
- Write msip: write 0x0000=1 -> bus_ready exactly 1 cycle after valid, msip=1 the following cycle; read 0x0000 -> 1; write 0 -> msip=0.
- Timer fire: TICK_DIV=1; write mtimecmp hi=0, lo=20, then mtime lo=0, hi=0 -> mtip rises on the cycle mtime reaches 20 (+1 registered) and stays 1; write mtimecmp lo=1000 -> mtip=0 next cycle.
- Wrap and priority: write mtime lo=0xFFFFFFFF, hi=0 -> after 1 tick read hi=1, lo=0. A write in the same cycle as an increment keeps the written value exactly.
- Prescaler: TICK_DIV=4; clear mtime, wait 40 cycles -> mtime reads 10 (±1 for access latency).
- Decode: read an unselected address 0x1000_0000 -> bus_ready never asserts; read offset 0x0100 -> ready with rdata=0; back-to-back requests each get one ready pulse.
